// File: rtl/ceas_pkg.sv
// Shared types and helpers for the time-setting controller: FSM states,
// time-field limits and the wrap-around step used while editing.
package ceas_pkg;

  localparam int TIME_W  = 6;
  localparam int ORA_MAX = 23;
  localparam int MIN_MAX = 59;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    SET_ORA = 2'd1,
    SET_MIN = 2'd2,
    LOAD    = 2'd3
  } state_t;

  // Out-of-range counter values are treated as 0 when editing starts.
  function automatic logic [TIME_W-1:0] cap_or_zero(input logic [TIME_W-1:0] v,
                                                    input logic [TIME_W-1:0] vmax);
    return (v > vmax) ? '0 : v;
  endfunction

  function automatic logic [TIME_W-1:0] wrap_step(input logic [TIME_W-1:0] v,
                                                  input logic [TIME_W-1:0] vmax,
                                                  input logic              up,
                                                  input logic              dn);
    if (up && !dn)
      return (v == vmax) ? '0 : v + 1'b1;
    else if (dn && !up)
      return (v == '0) ? vmax : v - 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/setare_ora_buton_debounce.sv
// One button path: 2-FF synchroniser, counter debounce, registered press pulse.
// With AUTO_REPEAT_EN defined the debounced level is exported for auto-repeat.
module buton_debounce #(
  parameter int DEB_CNT = 50000,
  parameter int DEB_W   = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
`ifdef AUTO_REPEAT_EN
  ,
  output logic o_level
`endif
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic             r_press;
  logic [DEB_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      // Level only moves after DEB_CNT consecutive disagreeing samples.
      if (r_sync2 != r_level) begin
        if (r_cnt == DEB_W'(DEB_CNT - 1)) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;
`ifdef AUTO_REPEAT_EN
  assign o_level = r_level;
`endif

endmodule

// File: rtl/setare_ora.sv
// Button-driven hour/minute setter feeding the clock counter's load interface.
// Optional auto-repeat of held UP/DOWN is enabled by defining AUTO_REPEAT_EN.
module setare_ora
  import ceas_pkg::*;
#(
  parameter int DEB_CNT   = 50000,
  parameter int DEB_W     = 16,
  parameter int TIMEOUT_S = 30,
  parameter int REP_CNT   = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              tick_1hz,
  input  logic [TIME_W-1:0] ora_in,
  input  logic [TIME_W-1:0] minut_in,
  output logic              enable,
  output logic              load,
  output logic [TIME_W-1:0] ora_setata,
  output logic [TIME_W-1:0] min_setat,
  output logic              edit_ora,
  output logic              edit_min
);

  localparam int TO_W = $clog2(TIMEOUT_S + 1);

  state_t            r_state, w_state_nxt;
  logic [TIME_W-1:0] r_ora_edit, w_ora_nxt;
  logic [TIME_W-1:0] r_min_edit, w_min_nxt;
  logic [TO_W-1:0]   r_to_cnt, w_to_nxt;
  logic              w_timeout;
  logic              w_mode_ev, w_up_press, w_dn_press;
  logic              w_up_ev, w_dn_ev, w_any_ev;
  logic              w_in_set;

  assign w_in_set = (r_state == SET_ORA) || (r_state == SET_MIN);

`ifdef AUTO_REPEAT_EN
  localparam int REP_W = $clog2(2 * REP_CNT + 1);
  logic             w_mode_lvl, w_up_lvl, w_dn_lvl;
  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_first;
  logic             w_rep_hold, w_rep_hit;

  buton_debounce #(.DEB_CNT(DEB_CNT), .DEB_W(DEB_W)) u_deb_mode (
    .i_clk(clk), .i_rst_n(rst), .i_btn(btn_mode), .o_press(w_mode_ev), .o_level(w_mode_lvl));
  buton_debounce #(.DEB_CNT(DEB_CNT), .DEB_W(DEB_W)) u_deb_up (
    .i_clk(clk), .i_rst_n(rst), .i_btn(btn_up), .o_press(w_up_press), .o_level(w_up_lvl));
  buton_debounce #(.DEB_CNT(DEB_CNT), .DEB_W(DEB_W)) u_deb_down (
    .i_clk(clk), .i_rst_n(rst), .i_btn(btn_down), .o_press(w_dn_press), .o_level(w_dn_lvl));

  // First repeat after a double period, then one every REP_CNT cycles.
  assign w_rep_hold = w_in_set && (w_up_lvl ^ w_dn_lvl);
  assign w_rep_hit  = w_rep_hold &&
                      (r_rep_cnt == (r_rep_first ? REP_W'(2 * REP_CNT - 1) : REP_W'(REP_CNT - 1)));

  always_ff @(posedge clk) begin
    if (!rst || !w_rep_hold || w_up_press || w_dn_press) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else if (w_rep_hit) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
    end else begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end

  assign w_up_ev = w_up_press | (w_rep_hit & w_up_lvl);
  assign w_dn_ev = w_dn_press | (w_rep_hit & w_dn_lvl);
`else
  buton_debounce #(.DEB_CNT(DEB_CNT), .DEB_W(DEB_W)) u_deb_mode (
    .i_clk(clk), .i_rst_n(rst), .i_btn(btn_mode), .o_press(w_mode_ev));
  buton_debounce #(.DEB_CNT(DEB_CNT), .DEB_W(DEB_W)) u_deb_up (
    .i_clk(clk), .i_rst_n(rst), .i_btn(btn_up), .o_press(w_up_press));
  buton_debounce #(.DEB_CNT(DEB_CNT), .DEB_W(DEB_W)) u_deb_down (
    .i_clk(clk), .i_rst_n(rst), .i_btn(btn_down), .o_press(w_dn_press));

  assign w_up_ev = w_up_press;
  assign w_dn_ev = w_dn_press;
`endif

  assign w_any_ev = w_mode_ev | w_up_ev | w_dn_ev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= NORMAL;
      r_ora_edit <= '0;
      r_min_edit <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ora_edit <= w_ora_nxt;
      r_min_edit <= w_min_nxt;
      r_to_cnt   <= w_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ora_nxt   = r_ora_edit;
    w_min_nxt   = r_min_edit;
    w_to_nxt    = '0;
    w_timeout   = 1'b0;

    // Inactivity timer runs only while editing; any event restarts it.
    if (w_in_set && !w_any_ev) begin
      w_to_nxt = r_to_cnt;
      if (tick_1hz) begin
        if (r_to_cnt == TO_W'(TIMEOUT_S - 1))
          w_timeout = 1'b1;
        else
          w_to_nxt = r_to_cnt + 1'b1;
      end
      if (w_timeout)
        w_to_nxt = '0;
    end

    case (r_state)
      NORMAL: begin
        if (w_mode_ev) begin
          w_ora_nxt   = cap_or_zero(ora_in, TIME_W'(ORA_MAX));
          w_min_nxt   = cap_or_zero(minut_in, TIME_W'(MIN_MAX));
          w_state_nxt = SET_ORA;
        end
      end
      SET_ORA: begin
        if (w_mode_ev)
          w_state_nxt = SET_MIN;
        else if (w_timeout)
          w_state_nxt = NORMAL;
        else
          w_ora_nxt = wrap_step(r_ora_edit, TIME_W'(ORA_MAX), w_up_ev, w_dn_ev);
      end
      SET_MIN: begin
        if (w_mode_ev)
          w_state_nxt = LOAD;
        else if (w_timeout)
          w_state_nxt = NORMAL;
        else
          w_min_nxt = wrap_step(r_min_edit, TIME_W'(MIN_MAX), w_up_ev, w_dn_ev);
      end
      LOAD:    w_state_nxt = NORMAL;
      default: w_state_nxt = NORMAL;
    endcase
  end

  assign enable     = tick_1hz & (r_state == NORMAL);
  assign load       = (r_state == LOAD);
  assign edit_ora   = (r_state == SET_ORA);
  assign edit_min   = (r_state == SET_MIN);
  assign ora_setata = r_ora_edit;
  assign min_setat  = r_min_edit;

endmodule

// File: tb/tb_setare_ora.sv
// Self-checking bench for setare_ora: directed scenarios plus random button/tick
// traffic compared against an event-level model of the time-setting rules.
module tb_setare_ora;

  localparam int DEB_CNT   = 4;
  localparam int TIMEOUT_S = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       tick_1hz = 1'b0;
  logic [5:0] ora_in = '0, minut_in = '0;
  logic       enable, load, edit_ora, edit_min;
  logic [5:0] ora_setata, min_setat;

  always #5 clk = ~clk;

  setare_ora #(.DEB_CNT(DEB_CNT), .DEB_W(4), .TIMEOUT_S(TIMEOUT_S), .REP_CNT(8)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .tick_1hz(tick_1hz), .ora_in(ora_in), .minut_in(minut_in), .enable(enable),
    .load(load), .ora_setata(ora_setata), .min_setat(min_setat),
    .edit_ora(edit_ora), .edit_min(edit_min));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Load-strobe and enable monitor
  int   load_cnt = 0, load_wide = 0, en_viol = 0, cap_ora = 0, cap_min = 0;
  logic load_prev = 1'b0;
  always @(negedge clk) begin
    if (load) begin
      load_cnt <= load_cnt + 1;
      cap_ora  <= int'(ora_setata);
      cap_min  <= int'(min_setat);
      if (load_prev) load_wide <= load_wide + 1;
    end
    load_prev <= load;
    if ((edit_ora || edit_min) && enable) en_viol <= en_viol + 1;
  end

  // Event-level reference model: 0=normal, 1=editing hour, 2=editing minute
  int m_st = 0, m_ora = 0, m_min = 0, m_to = 0, m_loads = 0;
  bit m_loaded = 0;
  int last_lat = 0;

  function automatic void model_apply(input bit m, input bit u, input bit d);
    m_loaded = 0;
    case (m_st)
      0: if (m) begin
        m_ora = (int'(ora_in) > 23) ? 0 : int'(ora_in);
        m_min = (int'(minut_in) > 59) ? 0 : int'(minut_in);
        m_st  = 1;
        m_to  = 0;
      end
      1: begin
        if (m || u || d) m_to = 0;
        if (m) m_st = 2;
        else if (u && !d) m_ora = (m_ora + 1) % 24;
        else if (d && !u) m_ora = (m_ora + 23) % 24;
      end
      default: begin
        if (m || u || d) m_to = 0;
        if (m) begin
          m_st = 0;
          m_loads++;
          m_loaded = 1;
        end
        else if (u && !d) m_min = (m_min + 1) % 60;
        else if (d && !u) m_min = (m_min + 59) % 60;
      end
    endcase
  endfunction

  function automatic logic [13:0] snap();
    return {edit_ora, edit_min, ora_setata, min_setat};
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_edit_ora"}, int'(edit_ora), int'(m_st == 1));
    chk({tag, "_edit_min"}, int'(edit_min), int'(m_st == 2));
    chk({tag, "_ora"}, int'(ora_setata), m_ora);
    chk({tag, "_min"}, int'(min_setat), m_min);
    chk({tag, "_loads"}, load_cnt, m_loads);
  endtask

  task automatic press(input bit m, input bit u, input bit d);
    logic [13:0] s0;
    s0 = snap();
    @(posedge clk); #1;
    btn_mode = m; btn_up = u; btn_down = d;
    last_lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (last_lat == 0 && snap() != s0) last_lat = i;
    end
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    model_apply(m, u, d);
    check_state("press");
    if (m_loaded) begin
      chk("load_ora", cap_ora, m_ora);
      chk("load_min", cap_min, m_min);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    tick_1hz = 1'b1;
    @(negedge clk);
    chk("enable_tick", int'(enable), int'(m_st == 0));
    @(posedge clk); #1;
    tick_1hz = 1'b0;
    if (m_st != 0) begin
      m_to++;
      if (m_to == TIMEOUT_S) begin
        m_st = 0;
        m_to = 0;
      end
    end
    check_state("tick");
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    m_st = 0; m_ora = 0; m_min = 0; m_to = 0;
    check_state("rst");
    chk("rst_load", int'(load), 0);
  endtask

  initial begin
    int l0;
    int r;
    bit bm, bu, bd;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check_state("reset");
    chk("reset_load", int'(load), 0);
    tick_1hz = 1'b1; #1;
    chk("reset_en_hi", int'(enable), 1);
    tick_1hz = 1'b0; #1;
    chk("reset_en_lo", int'(enable), 0);

    // Full set sequence with bounce rejection and latency
    ora_in = 6'd22; minut_in = 6'd58;
    press(1, 0, 0);
    chk("mode_latency", last_lat, DEB_CNT + 4);
    @(posedge clk); #1;
    btn_up = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    btn_up = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_state("glitch");
    chk("glitch_ora", int'(ora_setata), 22);
    press(0, 1, 0);
    chk("up_latency", last_lat, DEB_CNT + 4);
    press(0, 1, 0);
    press(1, 0, 0);
    repeat (3) press(0, 1, 0);
    l0 = load_cnt;
    press(1, 0, 0);
    chk("seq_ora", cap_ora, 0);
    chk("seq_min", cap_min, 1);
    chk("seq_one_load", load_cnt - l0, 1);
    chk("seq_load_width", load_wide, 0);

    // Down wrap
    ora_in = 6'd0; minut_in = 6'd0;
    press(1, 0, 0);
    press(0, 0, 1);
    chk("down_wrap_ora", int'(ora_setata), 23);
    press(1, 0, 0);
    press(0, 0, 1);
    chk("down_wrap_min", int'(min_setat), 59);
    press(1, 0, 0);

    // Out-of-range capture and timeout
    ora_in = 6'd24; minut_in = 6'd60;
    press(1, 0, 0);
    chk("cap24_ora", int'(ora_setata), 0);
    chk("cap60_min", int'(min_setat), 0);
    l0 = load_cnt;
    repeat (2) tick();
    chk("to_still_edit", int'(edit_ora), 1);
    tick();
    chk("to_back_normal", int'(edit_ora), 0);
    chk("to_no_load", load_cnt - l0, 0);

    // Priority and reset mid-edit
    ora_in = 6'd5; minut_in = 6'd7;
    press(1, 0, 0);
    press(1, 1, 0);
    chk("prio_state", int'(edit_min), 1);
    chk("prio_ora", int'(ora_setata), 5);
    l0 = load_cnt;
    do_reset();
    chk("rst_no_load", load_cnt - l0, 0);

    // Random traffic
    for (int it = 0; it < 200; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 6) begin
        do_reset();
      end else if (r < 35) begin
        tick();
      end else begin
        if (m_st == 0) begin
          ora_in   = 6'($urandom_range(0, 63));
          minut_in = 6'($urandom_range(0, 63));
        end
        bm = ($urandom_range(0, 99) < 30);
        bu = ($urandom_range(0, 99) < 45);
        bd = ($urandom_range(0, 99) < 45);
        press(bm, bu, bd);
      end
    end

    chk("final_load_width", load_wide, 0);
    chk("final_enable_gated", en_viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
